fetch_unit: RTL and testbench

Instruction fetch front end for the RV32E core. It issues word fetches to instruction memory over a valid/ready request port and receives in-order responses. Fetched instructions are buffered in a small prefetch FIFO and handed to the decode stage with their PC through a valid/ready handshake. A redirect from the execute stage (taken branch or jump) flushes the buffer and discards in-flight responses.

---
 rtl/fetch_unit.sv | 222 ++++++++++++++++++++++
 tb/tb_fetch_unit.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end for the RV32E core.
// Issues word fetches over a valid/ready request port and buffers the
// in-order responses in a small prefetch FIFO. The FIFO feeds decode
// through a valid/ready handshake. A redirect flushes the buffer and drops
// the responses still in flight.
// Optional feature macro: FETCH_BYPASS_EN. When it is defined, a response
// that arrives while the FIFO is empty goes straight to decode in the same
// cycle.
module fetch_unit #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] boot_addr,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        if_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0]   DEPTH_W  = (CW+1)'(DEPTH);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [AW-1:0] PTR_ZERO = AW'(0);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [31:0]   NOP      = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_resp_pc;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_drop_cnt;
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [31:0]   r_mem_instr [DEPTH];
    logic [31:0]   r_mem_pc    [DEPTH];

    logic          w_accept;
    logic          w_rsp_dec;
    logic          w_rsp_run;
    logic          w_bypass;
    logic          w_pop;
    logic          w_pop_fifo;
    logic          w_push;
    logic          w_drop_dec;
    logic [CW-1:0] w_out_nxt;
    logic [CW:0]   w_inflight;
    logic [31:0]   w_redirect_tgt;

    assign w_redirect_tgt = {redirect_pc[31:2], 2'b00};
    assign w_inflight     = {1'b0, r_count} + {1'b0, r_outstanding};
    assign w_accept       = imem_req_valid && imem_req_ready;
    // A response with nothing outstanding (e.g. one left over from before a reset) is ignored by the counter.
    assign w_rsp_dec      = imem_rsp_valid && (r_outstanding != CNT_ZERO);
    assign w_out_nxt      = r_outstanding + CW'(w_accept) - CW'(w_rsp_dec);
    // Only responses that arrive in RUN without a redirect that same cycle are kept.
    assign w_rsp_run      = imem_rsp_valid && (r_state == ST_RUN) && !redirect;
`ifdef FETCH_BYPASS_EN
    assign w_bypass       = w_rsp_run && (r_count == CNT_ZERO);
`else
    assign w_bypass       = 1'b0;
`endif
    assign w_pop          = if_valid && if_ready;
    assign w_pop_fifo     = w_pop && !w_bypass;
    assign w_push         = w_rsp_run && !(w_bypass && if_ready);
    assign w_drop_dec     = imem_rsp_valid && (r_drop_cnt != CNT_ZERO);
    assign imem_req_addr  = r_fetch_pc;

    // Request gate: buffered plus in-flight words never exceed the FIFO depth.
    always_comb begin
        imem_req_valid = 1'b0;
        if ((r_state == ST_RUN) && (w_inflight < DEPTH_W)) begin
            imem_req_valid = 1'b1;
        end else begin
            imem_req_valid = 1'b0;
        end
    end

    // Next-state logic; a redirect overrides from any state.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_BOOT:  w_state_nxt = ST_RUN;
            ST_RUN:   w_state_nxt = ST_RUN;
            ST_FLUSH: begin
                if ((r_drop_cnt == CNT_ZERO) || (w_drop_dec && (r_drop_cnt == CNT_ONE))) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_FLUSH;
                end
            end
            default:  w_state_nxt = ST_BOOT;
        endcase
        if (redirect) begin
            w_state_nxt = (w_out_nxt != CNT_ZERO) ? ST_FLUSH : ST_RUN;
        end else begin
            w_state_nxt = w_state_nxt;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Fetch and response PC tracking. A redirect wins over boot load and increments.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc <= 32'h0000_0000;
            r_resp_pc  <= 32'h0000_0000;
        end else if (redirect) begin
            r_fetch_pc <= w_redirect_tgt;
            r_resp_pc  <= w_redirect_tgt;
        end else if (r_state == ST_BOOT) begin
            r_fetch_pc <= boot_addr;
            r_resp_pc  <= boot_addr;
        end else begin
            if (w_accept) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end else begin
                r_fetch_pc <= r_fetch_pc;
            end
            if (w_rsp_run) begin
                r_resp_pc <= r_resp_pc + 32'd4;
            end else begin
                r_resp_pc <= r_resp_pc;
            end
        end
    end

    // Outstanding-request counter, and the number of stale responses still to drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outstanding <= CNT_ZERO;
            r_drop_cnt    <= CNT_ZERO;
        end else begin
            r_outstanding <= w_out_nxt;
            if (redirect) begin
                r_drop_cnt <= w_out_nxt;
            end else if ((r_state == ST_FLUSH) && w_drop_dec) begin
                r_drop_cnt <= r_drop_cnt - CNT_ONE;
            end else begin
                r_drop_cnt <= r_drop_cnt;
            end
        end
    end

    // FIFO pointers and occupancy. A redirect empties the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= PTR_ZERO;
            r_rptr  <= PTR_ZERO;
            r_count <= CNT_ZERO;
        end else if (redirect) begin
            r_wptr  <= PTR_ZERO;
            r_rptr  <= PTR_ZERO;
            r_count <= CNT_ZERO;
        end else begin
            r_wptr  <= w_push ? (r_wptr + PTR_ONE) : r_wptr;
            r_rptr  <= w_pop_fifo ? (r_rptr + PTR_ONE) : r_rptr;
            r_count <= r_count + CW'(w_push) - CW'(w_pop_fifo);
        end
    end

    // FIFO storage: each instruction word is stored with its PC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_instr[i] <= NOP;
                r_mem_pc[i]    <= 32'h0000_0000;
            end
        end else if (w_push) begin
            r_mem_instr[r_wptr] <= imem_rsp_data;
            r_mem_pc[r_wptr]    <= r_resp_pc;
        end else begin
            r_mem_instr[r_wptr] <= r_mem_instr[r_wptr];
            r_mem_pc[r_wptr]    <= r_mem_pc[r_wptr];
        end
    end

    // Decode-side view: the bypass word, else the FIFO head, else a NOP with valid low.
    always_comb begin
        if_valid = 1'b0;
        if_instr = NOP;
        if_pc    = 32'h0000_0000;
        if (w_bypass) begin
            if_valid = 1'b1;
            if_instr = imem_rsp_data;
            if_pc    = r_resp_pc;
        end else if (r_count != CNT_ZERO) begin
            if_valid = 1'b1;
            if_instr = r_mem_instr[r_rptr];
            if_pc    = r_mem_pc[r_rptr];
        end else begin
            if_valid = 1'b0;
            if_instr = NOP;
            if_pc    = 32'h0000_0000;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit. A memory model with configurable
// latency answers the requests. Each instruction that should reach decode is
// pushed to a scoreboard when its response is driven, and checked when
// decode pops it.
module tb_fetch_unit;

    localparam int DEPTH = 2;
    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] boot_addr;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;

    fetch_unit #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .boot_addr      (boot_addr),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_ready       (if_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] pc;
        int          due;
        bit          stale;
    } pend_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    pend_t       pend[$];
    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          lat = 1;
    int          n_acc = 0;
    int          n_pop = 0;
    logic [31:0] exp_pc = 32'h0;
    logic [31:0] first_pop_pc = 32'h0;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // One clock cycle: observe at negedge, then update the memory model after the edge.
    task automatic tick();
        bit          acc, pop, rsp, redir, stale_any;
        logic [31:0] acc_addr, acc_pc, rtgt;
        exp_t        e;
        pend_t       p;
        @(negedge clk);
        acc      = imem_req_valid && imem_req_ready;
        acc_addr = imem_req_addr;
        acc_pc   = exp_pc;
        pop      = if_valid && if_ready;
        rsp      = imem_rsp_valid;
        redir    = redirect;
        rtgt     = redirect_pc;
        stale_any = 1'b0;
        foreach (pend[i]) if (pend[i].stale) stale_any = 1'b1;
        if (acc) begin
            total++;
            if (acc_addr !== exp_pc) begin
                bad++;
                $display("FAIL req_addr: got %h want %h", acc_addr, exp_pc);
            end
            exp_pc = exp_pc + 32'd4;
            n_acc++;
        end
        if (pop) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL extra_instr: got pc %h instr %h, want no instruction", if_pc, if_instr);
            end else begin
                e = sb.pop_front();
                if ((if_pc !== e.pc) || (if_instr !== e.instr)) begin
                    bad++;
                    $display("FAIL if_data: got pc %h instr %h want pc %h instr %h", if_pc, if_instr, e.pc, e.instr);
                end
            end
            if (n_pop == 0) first_pop_pc = if_pc;
            n_pop++;
        end
        if (stale_any) begin
            total++;
            if (imem_req_valid !== 1'b0) begin
                bad++;
                $display("FAIL flush_req: got req_valid %b want 0 while stale responses pending", imem_req_valid);
            end
        end
        if (rsp) begin
            total++;
            if (int'(dut.r_count) >= DEPTH) begin
                bad++;
                $display("FAIL rsp_full: got occupancy %0d want < %0d on response", int'(dut.r_count), DEPTH);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rsp && (pend.size() > 0)) void'(pend.pop_front());
        if (acc) pend.push_back('{acc_addr, acc_pc, cyc + lat - 1, 1'b0});
        if (redir) begin
            foreach (pend[i]) pend[i].stale = 1'b1;
            sb.delete();
            exp_pc = {rtgt[31:2], 2'b00};
        end
        if ((pend.size() > 0) && (pend[0].due <= cyc)) begin
            p = pend[0];
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = instr_of(p.addr);
            if (!p.stale) sb.push_back('{p.pc, instr_of(p.pc)});
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
    endtask

    task automatic do_reset(input logic [31:0] boot);
        rst_n          = 1'b0;
        redirect       = 1'b0;
        redirect_pc    = 32'h0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        boot_addr      = boot;
        pend.delete();
        sb.delete();
        n_acc = 0;
        n_pop = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        exp_pc = boot;
        cyc    = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; boot_addr = 32'h100; imem_req_ready = 1'b1; if_ready = 1'b1;
        redirect = 1'b0; redirect_pc = 32'h0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0; lat = 1;
        @(posedge clk);
        #2;
        total += 5;
        if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL rst_req_valid: got %b want 0", imem_req_valid); end
        if (imem_req_addr !== 32'h0) begin bad++; $display("FAIL rst_req_addr: got %h want 0", imem_req_addr); end
        if (if_valid !== 1'b0) begin bad++; $display("FAIL rst_if_valid: got %b want 0", if_valid); end
        if (if_instr !== NOP) begin bad++; $display("FAIL rst_if_instr: got %h want %h", if_instr, NOP); end
        if (if_pc !== 32'h0) begin bad++; $display("FAIL rst_if_pc: got %h want 0", if_pc); end
        @(posedge clk);
        #1;
        rst_n = 1'b1; exp_pc = 32'h100; cyc = 0; pend.delete(); sb.delete(); n_acc = 0; n_pop = 0;
        #1;
        total++;
        if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL boot_req_valid: got %b want 0", imem_req_valid); end
        tick();
        #1;
        total += 2;
        if (imem_req_valid !== 1'b1) begin bad++; $display("FAIL first_req_valid: got %b want 1", imem_req_valid); end
        if (imem_req_addr !== 32'h100) begin bad++; $display("FAIL first_req_addr: got %h want 00000100", imem_req_addr); end
        repeat (5) tick();
        #2;
        rst_n = 1'b0;
        #1;
        total += 3;
        if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL midrst_req_valid: got %b want 0", imem_req_valid); end
        if (if_valid !== 1'b0) begin bad++; $display("FAIL midrst_if_valid: got %b want 0", if_valid); end
        if (if_instr !== NOP) begin bad++; $display("FAIL midrst_if_instr: got %h want %h", if_instr, NOP); end
    endtask

    task automatic test_stream();
        bit seen = 1'b0;
        lat = 1; imem_req_ready = 1'b1; if_ready = 1'b1;
        do_reset(32'h100);
        for (int i = 0; i < 24; i++) begin
            tick();
            if (!seen && imem_rsp_valid) begin
                seen = 1'b1;
                #1;
                total++;
                if (if_valid !== BYP) begin
                    bad++;
                    $display("FAIL rsp_latency: got if_valid %b want %b in response cycle", if_valid, BYP);
                end
            end
        end
        total += 2;
        if (first_pop_pc !== 32'h100) begin bad++; $display("FAIL stream_first_pc: got %h want 00000100", first_pop_pc); end
        if (n_pop < 10) begin bad++; $display("FAIL stream_count: got %0d want >= 10", n_pop); end
    endtask

    task automatic test_if_stall();
        lat = 1; imem_req_ready = 1'b1; if_ready = 1'b0;
        do_reset(32'h100);
        repeat (10) tick();
        #1;
        total += 3;
        if (n_acc != 2) begin bad++; $display("FAIL stall_accepts: got %0d want 2", n_acc); end
        if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL stall_req_valid: got %b want 0", imem_req_valid); end
        if (n_pop != 0) begin bad++; $display("FAIL stall_pops: got %0d want 0", n_pop); end
        if_ready = 1'b1;
        repeat (6) tick();
        total += 2;
        if (first_pop_pc !== 32'h100) begin bad++; $display("FAIL stall_first_pc: got %h want 00000100", first_pop_pc); end
        if (n_pop < 2) begin bad++; $display("FAIL stall_release: got %0d pops want >= 2", n_pop); end
    endtask

    task automatic test_req_stall();
        bit found = 1'b0;
        int a0;
        lat = 1; imem_req_ready = 1'b1; if_ready = 1'b1;
        do_reset(32'h100);
        for (int i = 0; i < 20; i++) begin
            if (!found) begin
                tick();
                if (exp_pc == 32'h108) found = 1'b1;
            end
        end
        total++;
        if (!found) begin bad++; $display("FAIL hold_setup: got no accept of 00000104 within 20 cycles"); end
        imem_req_ready = 1'b0;
        a0 = n_acc;
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            total++;
            if (imem_req_addr !== 32'h108) begin bad++; $display("FAIL hold_addr: got %h want 00000108", imem_req_addr); end
        end
        total += 2;
        if (n_acc != a0) begin bad++; $display("FAIL hold_accepts: got %0d want %0d", n_acc, a0); end
        if (imem_req_valid !== 1'b1) begin bad++; $display("FAIL hold_valid: got %b want 1", imem_req_valid); end
        imem_req_ready = 1'b1;
        tick();
        total++;
        if (n_acc != a0 + 1) begin bad++; $display("FAIL hold_release: got %0d accepts want %0d", n_acc, a0 + 1); end
        repeat (6) tick();
    endtask

    task automatic test_redirect();
        lat = 3; imem_req_ready = 1'b1; if_ready = 1'b1;
        do_reset(32'h100);
        for (int i = 0; i < 10; i++) begin
            if (n_acc < 2) tick();
        end
        total++;
        if (n_acc != 2) begin bad++; $display("FAIL redir_setup: got %0d accepts want 2", n_acc); end
        redirect = 1'b1; redirect_pc = 32'h0000_0203;
        tick();
        redirect = 1'b0;
        n_pop = 0;
        #1;
        total += 2;
        if (if_valid !== 1'b0) begin bad++; $display("FAIL redir_flush: got if_valid %b want 0", if_valid); end
        if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL redir_no_req: got %b want 0", imem_req_valid); end
        repeat (14) tick();
        total++;
        if ((n_pop == 0) || (first_pop_pc !== 32'h200)) begin
            bad++;
            $display("FAIL redir_target: got pc %h after %0d pops want 00000200", first_pop_pc, n_pop);
        end
    endtask

    task automatic test_redirect_collide();
        bit found = 1'b0;
        lat = 1; imem_req_ready = 1'b1; if_ready = 1'b1;
        do_reset(32'h100);
        for (int i = 0; i < 20; i++) begin
            if (!found) begin
                tick();
                #1;
                if (imem_rsp_valid && imem_req_valid && imem_req_ready) found = 1'b1;
            end
        end
        total++;
        if (!found) begin bad++; $display("FAIL collide_setup: got no response+accept cycle within 20 cycles"); end
        redirect = 1'b1; redirect_pc = 32'h0000_0400;
        tick();
        redirect = 1'b0;
        n_pop = 0;
        #1;
        total++;
        if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL collide_drop: got req_valid %b want 0", imem_req_valid); end
        repeat (8) tick();
        total++;
        if ((n_pop == 0) || (first_pop_pc !== 32'h400)) begin
            bad++;
            $display("FAIL collide_target: got pc %h after %0d pops want 00000400", first_pop_pc, n_pop);
        end
    endtask

    task automatic test_wrap();
        lat = 1; imem_req_ready = 1'b1; if_ready = 1'b1;
        do_reset(32'hFFFF_FFF8);
        repeat (12) tick();
        total += 2;
        if (first_pop_pc !== 32'hFFFF_FFF8) begin bad++; $display("FAIL wrap_first_pc: got %h want fffffff8", first_pop_pc); end
        if (n_pop < 3) begin bad++; $display("FAIL wrap_count: got %0d want >= 3", n_pop); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_if_stall();
        test_req_stall();
        test_redirect();
        test_redirect_collide();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
